// File: rtl/pc_sequencer.sv
// Program-counter sequencer: produces fetch requests with a valid/ready
// handshake, sequential stepping, redirect/trap targets, pending-target capture and halt.
module pc_sequencer #(
  parameter int          XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int          STEP         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic            redirect_jalr,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_imm,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            misalign_err,
  output logic [1:0]      o_dbg_state
);

  // Handshake: a request (pc) is offered while fetch_valid=1 and is accepted
  // in the cycle fetch_ready=1; once offered, pc and fetch_valid stay put until accepted.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  state_t          r_state, w_state_n;
  logic [XLEN-1:0] r_pc, w_pc_n;
  logic [XLEN-1:0] r_pend_addr, w_pend_addr_n;
  logic            r_pend_valid, w_pend_valid_n;
  logic            r_pend_trap, w_pend_trap_n;
  logic            r_halt_lat, w_halt_lat_n;
  logic            r_misalign, w_misalign_n;

  logic            w_fetch_valid;
  logic            w_handshake;
  logic            w_slot;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_redir_tgt;

  assign w_sum       = redirect_base + redirect_imm;
  assign w_redir_tgt = redirect_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

  always_comb begin
    w_fetch_valid = 1'b0;
    case (r_state)
      S_RUN:   w_fetch_valid = !stall;
      S_WAIT:  w_fetch_valid = 1'b1;
      default: w_fetch_valid = 1'b0;
    endcase
  end

  assign w_handshake = w_fetch_valid && fetch_ready;
  // An update slot is any RUN/WAIT cycle that does not leave a request unaccepted.
  assign w_slot = ((r_state == S_RUN) && !(w_fetch_valid && !fetch_ready)) ||
                  ((r_state == S_WAIT) && fetch_ready);

  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_pend_addr_n  = r_pend_addr;
    w_pend_valid_n = r_pend_valid;
    w_pend_trap_n  = r_pend_trap;
    w_halt_lat_n   = r_halt_lat;
    w_misalign_n   = 1'b0;
    case (r_state)
      S_BOOT: w_state_n = S_RUN;
      S_RUN, S_WAIT: begin
        if (w_slot) begin
          if (trap_valid) begin
            w_pc_n       = trap_vec;
            w_misalign_n = (trap_vec & ALIGN_MASK) != '0;
          end else if (redirect_valid) begin
            w_pc_n       = w_redir_tgt;
            w_misalign_n = (w_redir_tgt & ALIGN_MASK) != '0;
          end else if (r_pend_valid) begin
            w_pc_n = r_pend_addr;
          end else if (w_handshake) begin
            w_pc_n = r_pc + STEP_X;
          end
          w_pend_valid_n = 1'b0;
          w_pend_trap_n  = 1'b0;
          w_halt_lat_n   = 1'b0;
          w_state_n      = (halt || r_halt_lat) ? S_HALT : S_RUN;
        end else begin
          // Request outstanding: remember what arrived and apply it on acceptance.
          w_state_n = S_WAIT;
          if (halt) w_halt_lat_n = 1'b1;
          if (trap_valid) begin
            w_pend_addr_n  = trap_vec;
            w_pend_valid_n = 1'b1;
            w_pend_trap_n  = 1'b1;
          end else if (redirect_valid && !r_pend_trap) begin
            w_pend_addr_n  = w_redir_tgt;
            w_pend_valid_n = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (trap_valid) begin
          w_pc_n       = trap_vec;
          w_misalign_n = (trap_vec & ALIGN_MASK) != '0;
          w_state_n    = S_RUN;
        end
      end
      default: w_state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_VECTOR;
      r_pend_addr  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_halt_lat   <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_pend_addr  <= w_pend_addr_n;
      r_pend_valid <= w_pend_valid_n;
      r_pend_trap  <= w_pend_trap_n;
      r_halt_lat   <= w_halt_lat_n;
      r_misalign   <= w_misalign_n;
    end
  end

  assign fetch_valid  = w_fetch_valid;
  assign pc           = r_pc;
  assign pc_next_seq  = r_pc + STEP_X;
  assign misalign_err = r_misalign;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the PC and target width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter STEP, default 4, giving the sequential increment; legal values are 2 and 4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port stall, input, 1 bit: downstream hazard; suppresses a new fetch request.
REQ-007 The block SHALL have port halt, input, 1 bit: request to stop fetching.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: branch or jump taken.
REQ-009 The block SHALL have port redirect_jalr, input, 1 bit: 0 gives target = base+imm; 1 gives target = (base+imm) with bit 0 cleared.
REQ-010 The block SHALL have ports redirect_base and redirect_imm, input, XLEN bits each: the operands of the redirect target.
REQ-011 The block SHALL have port trap_valid, input, 1 bit: trap or exception entry.
REQ-012 The block SHALL have port trap_vec, input, XLEN bits: the trap handler address.
REQ-013 The block SHALL have port fetch_ready, input, 1 bit: the instruction memory accepts the request.
REQ-014 The block SHALL have port fetch_valid, output, 1 bit: the current pc is a valid fetch request.
REQ-015 The block SHALL have port pc, output, XLEN bits: the current fetch address (registered).
REQ-016 The block SHALL have port pc_next_seq, output, XLEN bits: pc+STEP, combinational.
REQ-017 The block SHALL have port misalign_err, output, 1 bit: registered one-cycle flag for a misaligned loaded target.

Function
REQ-018 The block SHALL use states BOOT, RUN, WAIT and HALT.
REQ-019 In BOOT, fetch_valid SHALL be 0, and the block SHALL go to RUN on the next cycle.
REQ-020 In RUN, fetch_valid SHALL be !stall.
REQ-021 In WAIT, fetch_valid SHALL be 1 and pc SHALL be held.
REQ-022 In HALT, fetch_valid SHALL be 0 and pc SHALL be held.
REQ-023 A handshake SHALL be defined as fetch_valid && fetch_ready in the same cycle.
REQ-024 Stability rule: once fetch_valid=1 without fetch_ready, pc and fetch_valid SHALL stay unchanged until the handshake, regardless of stall, halt, redirect_valid or trap_valid.
REQ-025 When RUN has fetch_valid=1 and fetch_ready=0, the block SHALL go to WAIT.
REQ-026 An update slot SHALL occur in RUN with no unaccepted request at cycle end, and in WAIT on the handshake.
REQ-027 The next-PC priority at an update slot SHALL be: trap_valid (trap_vec), then redirect_valid (redirect target), then the pending target, then handshake (pc+STEP), else pc.
REQ-028 Outside an update slot in RUN or WAIT, trap_valid SHALL write pend_addr<=trap_vec and set pend_valid and pend_trap.
REQ-029 Outside an update slot, redirect_valid SHALL write pend_addr only if pend_trap=0; a same-cycle trap SHALL win.
REQ-030 Consuming the pending target SHALL clear pend_valid and pend_trap.
REQ-031 A trap or redirect coincident with an update slot SHALL take precedence over, and clear, any pending target.
REQ-032 halt seen at a RUN update slot SHALL move the block to HALT after that slot's PC update.
REQ-033 halt seen during WAIT SHALL be latched, and the block SHALL move to HALT at the handshake.
REQ-034 In HALT, only trap_valid (pc<=trap_vec, go to RUN) or rst SHALL exit; redirect_valid SHALL be ignored in HALT.
REQ-035 All target arithmetic SHALL be XLEN-bit modulo 2^XLEN; pc+STEP from all-ones SHALL wrap to STEP-1.
REQ-036 misalign_err SHALL be 1 in the cycle after loading a trap or redirect target with (target mod STEP) != 0; the target SHALL still be loaded.
REQ-037 misalign_err SHALL be 0 otherwise, including for pending targets when they are consumed.

Reset
REQ-038 rst=1 SHALL force state BOOT, pc=RESET_VECTOR, fetch_valid=0, misalign_err=0, pend_valid=0, pend_trap=0 and halt latch=0 at the next edge.
REQ-039 rst SHALL override all other inputs, including a request outstanding in WAIT.
REQ-040 The first fetch request after reset SHALL be RESET_VECTOR, one cycle after rst falls.

Verification
REQ-041 The bench SHALL cover this case: rst, then fetch_ready=1, stall=0 gives pc 0, 4, 8, 12 with fetch_valid high from cycle 2.
REQ-042 The bench SHALL cover this case: fetch_ready=0 for 3 cycles at pc=8 with redirect base=0x100, imm=0x20 in cycle 1 gives pc held at 8 and fetch_valid held; after ready, pc=0x120.
REQ-043 The bench SHALL cover this case: in WAIT, redirect then trap_vec=0x80 then redirect gives pc=0x80 after the handshake.
REQ-044 The bench SHALL cover this case: jalr base=0x103, imm=0 gives pc=0x102 and misalign_err=1 for one cycle (STEP=4).
REQ-045 The bench SHALL cover this case: halt at pc=0x10 gives HALT with fetch_valid=0; a redirect is ignored; trap_vec=0x200 gives RUN and pc=0x200.
REQ-046 The bench SHALL cover this case: XLEN=16, pc=0xFFFC with a handshake gives pc=0x0000.
